// File: rtl/seg7_reader.sv
// Multiplexed 7-segment scan reader: debounces each digit visit, decodes it to BCD and
// frames four digits behind a valid/ready handshake. Optional decimal points: SEG7_READER_DP_EN.
module seg7_reader #(
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
`ifdef SEG7_READER_DP_EN
  input  logic        dp,
  output logic [3:0]  dp_out,
`endif
  output logic [15:0] bcd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err,
  output logic        overrun
);

`ifdef SEG7_READER_DP_EN
  localparam int SW = 12;
`else
  localparam int SW = 11;
`endif
  localparam logic [7:0] STABLE = 8'(STABLE_CNT);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  logic [SW-1:0] w_raw;
  logic [SW-1:0] r_s;
  logic [SW-1:0] r_p;
  logic [3:0]    w_s_an;
  logic [6:0]    w_s_seg;
  logic [3:0]    w_an_low;
  logic          w_onehot;
  logic [7:0]    r_cnt;
  logic [7:0]    w_cnt_next;
  logic          w_capture;
  logic [3:0]    w_sel;
  logic [3:0]    w_dec_bcd;
  logic          w_dec_err;
  logic [3:0]    r_dig [4];
  logic          r_dig_err [4];
  logic [3:0]    w_dig_next [4];
  logic          w_err_next [4];
  logic [15:0]   w_frame_bcd;
  logic          w_frame_err;
  logic [3:0]    r_mask;
  logic [3:0]    w_mask_set;
  logic [3:0]    w_mask_next;
  logic          w_full;
  state_t        r_state;
  state_t        w_state_next;
  logic          w_load;
  logic          w_set_ovr;
  logic [15:0]   r_bcd;
  logic          r_err;
  logic          r_ovr;

`ifdef SEG7_READER_DP_EN
  assign w_raw = {dp, an, seg};
`else
  assign w_raw = {an, seg};
`endif

  assign w_s_an   = r_s[10:7];
  assign w_s_seg  = r_s[6:0];
  assign w_an_low = ~w_s_an;
  assign w_onehot = (w_an_low != 4'd0) && ((w_an_low & (w_an_low - 4'd1)) == 4'd0);

  // Reset to "no digit enabled" so the first real sample starts a fresh run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s <= '1;
      r_p <= '1;
    end else begin
      r_s <= w_raw;
      r_p <= r_s;
    end
  end

  always_comb begin
    w_cnt_next = 8'd0;
    if (w_onehot) begin
      if (r_s == r_p) begin
        w_cnt_next = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
      end else begin
        w_cnt_next = 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  // Capture only on the transition into STABLE so a long visit yields one capture.
  assign w_capture = (w_cnt_next == STABLE) && (r_cnt != STABLE);
  assign w_sel     = w_an_low & {4{w_capture}};

  always_comb begin
    w_dec_bcd = 4'hF;
    w_dec_err = 1'b1;
    case (w_s_seg)
      7'b1000000: begin w_dec_bcd = 4'd0; w_dec_err = 1'b0; end
      7'b1111001: begin w_dec_bcd = 4'd1; w_dec_err = 1'b0; end
      7'b0100100: begin w_dec_bcd = 4'd2; w_dec_err = 1'b0; end
      7'b0110000: begin w_dec_bcd = 4'd3; w_dec_err = 1'b0; end
      7'b0011001: begin w_dec_bcd = 4'd4; w_dec_err = 1'b0; end
      7'b0010010: begin w_dec_bcd = 4'd5; w_dec_err = 1'b0; end
      7'b0000010: begin w_dec_bcd = 4'd6; w_dec_err = 1'b0; end
      7'b1111000: begin w_dec_bcd = 4'd7; w_dec_err = 1'b0; end
      7'b0000000: begin w_dec_bcd = 4'd8; w_dec_err = 1'b0; end
      7'b0010000: begin w_dec_bcd = 4'd9; w_dec_err = 1'b0; end
      default:    begin w_dec_bcd = 4'hF; w_dec_err = 1'b1; end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign w_dig_next[gi] = w_sel[gi] ? w_dec_bcd : r_dig[gi];
    assign w_err_next[gi] = w_sel[gi] ? w_dec_err : r_dig_err[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_dig[gi]     <= 4'd0;
        r_dig_err[gi] <= 1'b0;
      end else begin
        r_dig[gi]     <= w_dig_next[gi];
        r_dig_err[gi] <= w_err_next[gi];
      end
    end
  end

  // The frame includes a digit captured in the same cycle the mask completes.
  assign w_frame_bcd = {w_dig_next[3], w_dig_next[2], w_dig_next[1], w_dig_next[0]};
  assign w_frame_err = w_err_next[3] | w_err_next[2] | w_err_next[1] | w_err_next[0];
  assign w_mask_set  = r_mask | w_sel;
  assign w_full      = (w_mask_set == 4'hF);

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_set_ovr    = 1'b0;
    w_mask_next  = w_full ? 4'd0 : w_mask_set;
    case (r_state)
      COLLECT: begin
        if (w_full) begin
          w_load       = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (w_full) begin
          if (out_ready) begin
            w_load = 1'b1;
          end else begin
            w_set_ovr = 1'b1;
          end
        end else if (out_ready) begin
          w_state_next = COLLECT;
        end
      end
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
      r_mask  <= 4'd0;
      r_bcd   <= 16'd0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= w_mask_next;
      if (w_load) begin
        r_bcd <= w_frame_bcd;
        r_err <= w_frame_err;
      end
      if (w_set_ovr) begin
        r_ovr <= 1'b1;
      end
    end
  end

`ifdef SEG7_READER_DP_EN
  logic       r_dp_dig [4];
  logic       w_dp_next [4];
  logic [3:0] r_dp_out;

  // Decimal points are reported active-high (1 = point lit).
  for (genvar gi = 0; gi < 4; gi++) begin : g_dp
    assign w_dp_next[gi] = w_sel[gi] ? ~r_s[11] : r_dp_dig[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_dp_dig[gi] <= 1'b0;
      end else begin
        r_dp_dig[gi] <= w_dp_next[gi];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dp_out <= 4'd0;
    end else if (w_load) begin
      r_dp_out <= {w_dp_next[3], w_dp_next[2], w_dp_next[1], w_dp_next[0]};
    end
  end

  assign dp_out = r_dp_out;
`endif

  assign bcd       = r_bcd;
  assign err       = r_err;
  assign overrun   = r_ovr;
  assign out_valid = (r_state == HOLD);

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4 (range 2..255): consecutive identical samples required before a digit is captured.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port seg, input, 7 bits: segment lines, active-low; seg[0]=a ... seg[6]=g.
REQ-005 SHALL have port an, input, 4 bits: digit enables, active-low; an[0] is the least significant digit.
REQ-006 SHALL have port bcd, output, 16 bits: captured frame; digit i is bcd[4i+3:4i].
REQ-007 SHALL have port out_valid, output, 1 bit: bcd holds an unconsumed frame.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer accepts the frame.
REQ-009 SHALL have port err, output, 1 bit: the current bcd frame contains an illegal pattern.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag, a frame was dropped.

Function
REQ-011 SHALL register seg and an through one stage (s_seg, s_an); all decisions use the registered values.
REQ-012 SHALL treat a sample as one-hot only when exactly one bit of s_an is 0; all other samples reset the stability counter to 0.
REQ-013 SHALL increment a saturating stability counter when the sample is one-hot and equals the previous sample (same s_an, same s_seg), and reload it to 1 otherwise.
REQ-014 SHALL capture the selected digit exactly once per visit, in the cycle the counter reaches STABLE_CNT; no further capture until the counter reloads.
REQ-015 SHALL decode s_seg (g..a) as follows: 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
REQ-016 SHALL store 4'hF for any other pattern and set the error bit of that digit.
REQ-017 SHALL keep a 4-bit capture mask plus per-digit BCD and error registers; a capture sets the mask bit and overwrites the digit.
REQ-018 SHALL run an FSM with states COLLECT and HOLD.
REQ-019 In COLLECT, when the mask becomes 4'b1111, SHALL load bcd and err (OR of the digit error bits), assert out_valid, clear the mask and enter HOLD.
REQ-020 In HOLD, SHALL keep bcd and err stable and continue capturing into the mask; out_valid && out_ready returns the FSM to COLLECT.
REQ-021 SHALL set overrun and discard the new frame (then clear the mask) when a frame completes in HOLD without out_ready.
REQ-022 SHALL accept the old frame when completion and out_ready occur in the same HOLD cycle, load the new frame in that cycle and stay in HOLD with out_valid=1; overrun is not set.
REQ-023 SHALL produce the first out_valid no earlier than 1 + STABLE_CNT cycles after the last digit's enable becomes stable.

Reset
REQ-024 On rst=1 at a clock edge, SHALL set bcd=0, out_valid=0, err=0, overrun=0, mask=0, counter=0 and FSM=COLLECT, overriding any capture or handshake in the same cycle.
REQ-025 SHALL clear overrun only by reset.

Configuration
REQ-026 With SEG7_READER_DP_EN defined, SHALL add input dp (1 bit, active-low) and output dp_out (4 bits), captured and framed with the digits; dp joins the stability comparison.
REQ-027 Without SEG7_READER_DP_EN, SHALL have no dp or dp_out port and no dp logic.

Verification
REQ-028 SHALL cover: scan "1234" on an=1110,1101,1011,0111, 6 cycles each -> out_valid=1, bcd=16'h4321, err=0.
REQ-029 SHALL cover: digit held only STABLE_CNT-1 stable cycles -> no capture, mask bit stays 0, no out_valid.
REQ-030 SHALL cover: seg=1111111 on an[2] -> bcd[11:8]=4'hF, err=1.
REQ-031 SHALL cover: out_ready=0 while a second full scan completes -> bcd unchanged, overrun=1; out_ready=1 on the completion cycle instead -> new frame loaded, overrun=0.
REQ-032 SHALL cover: rst=1 mid-scan after 2 captures -> all outputs 0; the next complete scan alone produces out_valid.
REQ-033 SHALL cover: an=1100 (two enables low) for 10 cycles -> no capture.
